// File: rtl/twowire_apb_arbiter.sv
// ---------------------------------------------------------------------------
// twowire_apb_arbiter
//
// Shares one downstream APB3 completer between two upstream APB3 requesters.
// Arbitration is round-robin. The grant is held for the whole transfer.
// Each transfer takes one IDLE (decision) cycle, one SETUP cycle and one or
// more ACCESS cycles.
//
// Optional feature macro: TWOWIRE_ARB_TIMEOUT_EN
//   When this macro is defined, an ACCESS phase that waits TIMEOUT cycles
//   without dst_pready is aborted. The requester sees pready=1, pslverr=1
//   and prdata=0. When the macro is undefined, ACCESS waits for dst_pready
//   indefinitely and TIMEOUT has no effect.
//
// Handshake: a requester asserts sN_psel and holds its address, write flag
// and write data until it sees sN_pready=1. sN_penable is not used for the
// decision, so a request is accepted in IDLE whichever phase the requester
// is in. Downstream, dst_psel/dst_penable follow the standard APB SETUP ->
// ACCESS sequence, and a transfer ends in the first ACCESS cycle with
// dst_pready=1.
//
// Ports:
//   dck, drst_n           clock, asynchronous active-low reset
//   sN_psel/penable/pwrite/paddr/pwdata   requester N request (N = 0, 1)
//   sN_pready/pslverr/prdata              requester N response
//   dst_psel/penable/pwrite/paddr/pwdata  downstream request (registered)
//   dst_pready/pslverr/prdata             downstream response
//   grant                 current or most recently granted requester
// ---------------------------------------------------------------------------
module twowire_apb_arbiter #(
  parameter int W_ADDR  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              dck,
  input  logic              drst_n,
  input  logic              s0_psel,
  input  logic              s0_penable,
  input  logic              s0_pwrite,
  input  logic [W_ADDR-1:0] s0_paddr,
  input  logic [31:0]       s0_pwdata,
  output logic              s0_pready,
  output logic              s0_pslverr,
  output logic [31:0]       s0_prdata,
  input  logic              s1_psel,
  input  logic              s1_penable,
  input  logic              s1_pwrite,
  input  logic [W_ADDR-1:0] s1_paddr,
  input  logic [31:0]       s1_pwdata,
  output logic              s1_pready,
  output logic              s1_pslverr,
  output logic [31:0]       s1_prdata,
  output logic              dst_psel,
  output logic              dst_penable,
  output logic              dst_pwrite,
  output logic [W_ADDR-1:0] dst_paddr,
  output logic [31:0]       dst_pwdata,
  input  logic              dst_pready,
  input  logic              dst_pslverr,
  input  logic [31:0]       dst_prdata,
  output logic              grant
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [W_ADDR-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [31:0]         pwdata_q, pwdata_d;

  logic                pick;         // requester that wins in IDLE
  logic                timeout_hit;  // forced completion this cycle
  logic                done;         // transfer completes this cycle
  logic                rsp_err;
  logic [31:0]         rsp_data;

  // Penable is not needed for the decision. TIMEOUT is only read in the
  // timeout build.
  logic unused_ok;
  assign unused_ok = &{1'b0, s0_penable, s1_penable, TIMEOUT[0]};

  // On a tie, the requester that was not served last wins.
  assign pick = (s0_psel && s1_psel) ? ~last_q : s1_psel;

`ifdef TWOWIRE_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  // The counter is cleared in SETUP, so it reads 0 in the first ACCESS cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_SETUP) begin
      cnt_d = '0;
    end else if (state_q == ST_ACCESS && !dst_pready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge dck or negedge drst_n) begin
    if (!drst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A real response in the same cycle takes priority over the timeout.
  assign timeout_hit = (state_q == ST_ACCESS) && !dst_pready && (cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign done = (state_q == ST_ACCESS) && (dst_pready || timeout_hit);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    case (state_q)
      ST_IDLE: begin
        if (s0_psel || s1_psel) begin
          grant_d  = pick;
          paddr_d  = pick ? s1_paddr  : s0_paddr;
          pwrite_d = pick ? s1_pwrite : s0_pwrite;
          pwdata_d = pick ? s1_pwdata : s0_pwdata;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (done) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge dck or negedge drst_n) begin
    if (!drst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
    end
  end

  // Downstream controls depend only on state. No path runs from sN_psel.
  assign dst_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign dst_penable = (state_q == ST_ACCESS);
  assign dst_paddr   = paddr_q;
  assign dst_pwrite  = pwrite_q;
  assign dst_pwdata  = pwdata_q;
  assign grant       = grant_q;

  // A timed-out transfer reports an error and returns zero data.
  assign rsp_err  = dst_pready ? dst_pslverr : 1'b1;
  assign rsp_data = dst_pready ? dst_prdata  : 32'h0;

  assign s0_pready  = done && !grant_q;
  assign s1_pready  = done &&  grant_q;
  assign s0_pslverr = s0_pready && rsp_err;
  assign s1_pslverr = s1_pready && rsp_err;
  assign s0_prdata  = s0_pready ? rsp_data : 32'h0;
  assign s1_prdata  = s1_pready ? rsp_data : 32'h0;

endmodule

// File: tb/tb_twowire_apb_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for twowire_apb_arbiter. A transaction-level model tracks the
// transfer in flight: who owns it, what was latched, and how many cycles
// have passed since the grant. A compare process checks every output
// against this model on every cycle. Directed sequences pin the model with
// literal values. Random traffic then exercises the arbitration.
// Define TWOWIRE_ARB_TIMEOUT_EN to run the timeout build with TIMEOUT=4.
// ---------------------------------------------------------------------------
module tb_twowire_apb_arbiter;

  localparam int W = 8;
`ifdef TWOWIRE_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic dck;
  logic drst_n;
  logic s0_psel, s0_penable, s0_pwrite, s0_pready, s0_pslverr;
  logic s1_psel, s1_penable, s1_pwrite, s1_pready, s1_pslverr;
  logic [W-1:0] s0_paddr, s1_paddr, dst_paddr;
  logic [31:0] s0_pwdata, s1_pwdata, s0_prdata, s1_prdata;
  logic dst_psel, dst_penable, dst_pwrite, dst_pready, dst_pslverr;
  logic [31:0] dst_pwdata, dst_prdata;
  logic grant;

  // Per-requester drive variables, indexed by requester number.
  logic         r_psel[2];
  logic         r_penable[2];
  logic         r_pwrite[2];
  logic [W-1:0] r_paddr[2];
  logic [31:0]  r_pwdata[2];

  assign s0_psel = r_psel[0];   assign s1_psel = r_psel[1];
  assign s0_penable = r_penable[0]; assign s1_penable = r_penable[1];
  assign s0_pwrite = r_pwrite[0]; assign s1_pwrite = r_pwrite[1];
  assign s0_paddr = r_paddr[0]; assign s1_paddr = r_paddr[1];
  assign s0_pwdata = r_pwdata[0]; assign s1_pwdata = r_pwdata[1];

  twowire_apb_arbiter #(.W_ADDR(W), .TIMEOUT(TO)) dut (
    .dck(dck), .drst_n(drst_n),
    .s0_psel(s0_psel), .s0_penable(s0_penable), .s0_pwrite(s0_pwrite),
    .s0_paddr(s0_paddr), .s0_pwdata(s0_pwdata),
    .s0_pready(s0_pready), .s0_pslverr(s0_pslverr), .s0_prdata(s0_prdata),
    .s1_psel(s1_psel), .s1_penable(s1_penable), .s1_pwrite(s1_pwrite),
    .s1_paddr(s1_paddr), .s1_pwdata(s1_pwdata),
    .s1_pready(s1_pready), .s1_pslverr(s1_pslverr), .s1_prdata(s1_prdata),
    .dst_psel(dst_psel), .dst_penable(dst_penable), .dst_pwrite(dst_pwrite),
    .dst_paddr(dst_paddr), .dst_pwdata(dst_pwdata),
    .dst_pready(dst_pready), .dst_pslverr(dst_pslverr), .dst_prdata(dst_prdata),
    .grant(grant)
  );

  // ---------------- clock / reset ----------------
  initial dck = 1'b0;
  always #5 dck = ~dck;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          chk_en;
  bit          m_busy;     // a transfer owns the downstream bus
  int          m_age;      // cycles since grant: 0 = SETUP, >=1 = ACCESS
  bit          m_who;
  bit          m_grant;
  bit          m_last;
  logic [W-1:0] m_addr;
  bit          m_wr;
  logic [31:0] m_wdata;
  logic [W+33:0] exp_q[$];   // {who, write, addr, wdata} in grant order

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_who = 0; m_grant = 0; m_last = 1;
    m_addr = '0; m_wr = 0; m_wdata = '0;
    exp_q.delete();
  endtask

  function automatic bit model_timeout();
`ifdef TWOWIRE_ARB_TIMEOUT_EN
    return m_busy && (m_age == TO) && !dst_pready;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_done();
    return m_busy && (m_age >= 1) && (dst_pready || model_timeout());
  endfunction

  task automatic model_step();
    bit pick;
    if (!m_busy) begin
      if (r_psel[0] || r_psel[1]) begin
        pick = (r_psel[0] && r_psel[1]) ? !m_last : r_psel[1];
        m_busy = 1; m_age = 0; m_who = pick; m_grant = pick;
        m_addr = r_paddr[pick]; m_wr = r_pwrite[pick]; m_wdata = r_pwdata[pick];
        exp_q.push_back({pick, r_pwrite[pick], r_paddr[pick], r_pwdata[pick]});
      end
    end else if (model_done()) begin
      m_busy = 0;
      m_last = m_who;
    end else begin
      m_age++;
    end
  endtask

  task automatic compare_outputs();
    bit          e_done;
    bit          e_rdy[2];
    bit          e_err;
    logic [31:0] e_data;
    logic [W+33:0] got;
    e_done = model_done();
    e_err  = dst_pready ? dst_pslverr : 1'b1;
    e_data = dst_pready ? dst_prdata : 32'h0;
    e_rdy[0] = e_done && !m_who;
    e_rdy[1] = e_done && m_who;
    chk("dst_psel", dst_psel, m_busy);
    chk("dst_penable", dst_penable, m_busy && m_age >= 1);
    chk("grant", grant, m_grant);
    chk("dst_paddr", dst_paddr, m_addr);
    chk("dst_pwrite", dst_pwrite, m_wr);
    chk("dst_pwdata", dst_pwdata, m_wdata);
    chk("s0_pready", s0_pready, e_rdy[0]);
    chk("s1_pready", s1_pready, e_rdy[1]);
    chk("s0_pslverr", s0_pslverr, e_rdy[0] && e_err);
    chk("s1_pslverr", s1_pslverr, e_rdy[1] && e_err);
    chk("s0_prdata", s0_prdata, e_rdy[0] ? e_data : 32'h0);
    chk("s1_prdata", s1_prdata, e_rdy[1] ? e_data : 32'h0);
    if (s0_pready || s1_pready) begin
      got = {s1_pready, dst_pwrite, dst_paddr, dst_pwdata};
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_completion", got, '0);
      end else begin
        chk("sb_transfer", got, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge dck);
      #2;
      if (drst_n && chk_en) compare_outputs();
      @(posedge dck);
      if (!drst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- driver ----------------
  bit done_seen[2];
  bit b2b;
  int p_req;
  int p_rdy;
  bit track;
  int n_done[2];
  bit have_prev;
  bit prev_w;

  task automatic new_req(input int i);
    r_psel[i]    = 1'b1;
    r_penable[i] = 1'b0;
    r_pwrite[i]  = 1'($urandom_range(0, 1));
    r_paddr[i]   = W'($urandom);
    r_pwdata[i]  = $urandom;
  endtask

  // One cycle of random traffic. The requesters follow APB: a request is
  // held until pready. While its transfer is in flight, the owner scrambles
  // its bus to show that the downstream copy is registered.
  task automatic step();
    bit w;
    @(negedge dck);
    for (int i = 0; i < 2; i++) begin
      if (done_seen[i]) begin
        if (b2b || $urandom_range(0, 99) < p_req) new_req(i);
        else begin r_psel[i] = 1'b0; r_penable[i] = 1'b0; end
      end else if (r_psel[i]) begin
        r_penable[i] = 1'b1;
        if (m_busy && m_who == 1'(i) && $urandom_range(0, 3) == 0) begin
          r_paddr[i]  = W'($urandom);
          r_pwdata[i] = $urandom;
          r_pwrite[i] = ~r_pwrite[i];
        end
      end else if ($urandom_range(0, 99) < p_req) begin
        new_req(i);
      end
    end
    dst_pready  = ($urandom_range(0, 99) < p_rdy);
    dst_pslverr = 1'($urandom_range(0, 1));
    dst_prdata  = $urandom;
    #2;
    done_seen[0] = s0_pready;
    done_seen[1] = s1_pready;
    if (track && (s0_pready || s1_pready)) begin
      w = s1_pready;
      if (have_prev) chk("b2b_alternate", w, !prev_w);
      have_prev = 1; prev_w = w;
      n_done[w]++;
    end
  endtask

  task automatic drain();
    bit idle;
    b2b = 0; p_req = 0; p_rdy = 100; idle = 0;
    for (int k = 0; k < 100 && !idle; k++) begin
      step();
      idle = !r_psel[0] && !r_psel[1] && !m_busy;
    end
    chk("drain_idle", idle, 1'b1);
    done_seen[0] = 0; done_seen[1] = 0;
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(negedge dck);
    drst_n = 1'b0;
    @(posedge dck);
    @(negedge dck);
    drst_n = 1'b1;
    chk_en = 1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      r_psel[i] = 0; r_penable[i] = 0; r_pwrite[i] = 0;
      r_paddr[i] = '0; r_pwdata[i] = '0;
    end
    dst_pready = 0; dst_pslverr = 0; dst_prdata = '0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] ord_addr[2];
    logic [31:0]  ord_data[2];
    bit           ord_g[2];
    int           n_ord;
    bit           seen[2];
    int           n1, n0, idx1;
    bit           err1;

    clear_inputs();
    chk_en = 0;
    drst_n = 1'b0;
    done_seen[0] = 0; done_seen[1] = 0;
    b2b = 0; p_req = 0; p_rdy = 100; track = 0;

    // Reset values
    repeat (2) @(posedge dck);
    #2;
    chk("rst_dst_psel", dst_psel, 0);
    chk("rst_dst_penable", dst_penable, 0);
    chk("rst_grant", grant, 0);
    chk("rst_dst_paddr", dst_paddr, 0);
    chk("rst_dst_pwdata", dst_pwdata, 0);
    chk("rst_s0_pready", s0_pready, 0);
    chk("rst_s1_pready", s1_pready, 0);
    @(negedge dck);
    drst_n = 1'b1;
    chk_en = 1;

    // Single read on requester 0, pready tied high
    @(negedge dck);
    r_psel[0] = 1; r_paddr[0] = 8'h10; r_pwrite[0] = 0;
    dst_pready = 1; dst_prdata = 32'hCAFEF00D;
    #2 chk("rd_c0_dst_psel", dst_psel, 0);
    @(negedge dck);
    r_penable[0] = 1;
    #2;
    chk("rd_c1_dst_psel", dst_psel, 1);
    chk("rd_c1_dst_penable", dst_penable, 0);
    chk("rd_c1_dst_paddr", dst_paddr, 8'h10);
    @(negedge dck);
    #2;
    chk("rd_c2_s0_pready", s0_pready, 1);
    chk("rd_c2_s0_prdata", s0_prdata, 32'hCAFEF00D);
    chk("rd_c2_dst_paddr", dst_paddr, 8'h10);
    chk("rd_c2_dst_penable", dst_penable, 1);
    @(negedge dck);
    r_psel[0] = 0; r_penable[0] = 0;
    #2 chk("rd_c3_s0_pready", s0_pready, 0);

    // Simultaneous writes after reset: requester 0 wins the first tie
    do_reset();
    r_psel[0] = 1; r_pwrite[0] = 1; r_paddr[0] = 8'h04; r_pwdata[0] = 32'h11111111;
    r_psel[1] = 1; r_pwrite[1] = 1; r_paddr[1] = 8'h08; r_pwdata[1] = 32'h22222222;
    dst_pready = 1;
    n_ord = 0; seen[0] = 0; seen[1] = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge dck);
      for (int i = 0; i < 2; i++) if (seen[i]) begin r_psel[i] = 0; r_penable[i] = 0; end
      #2;
      if (dst_psel && !dst_penable && n_ord < 2) begin
        ord_g[n_ord] = grant; ord_addr[n_ord] = dst_paddr; ord_data[n_ord] = dst_pwdata;
        n_ord++;
      end
      if (grant == 1'b0) chk("tie_s1_rdy_while_g0", s1_pready, 0);
      seen[0] = s0_pready; seen[1] = s1_pready;
    end
    chk("tie_n_transfers", n_ord, 2);
    chk("tie_first_grant", ord_g[0], 0);
    chk("tie_first_addr", ord_addr[0], 8'h04);
    chk("tie_first_data", ord_data[0], 32'h11111111);
    chk("tie_second_grant", ord_g[1], 1);
    chk("tie_second_addr", ord_addr[1], 8'h08);
    chk("tie_second_data", ord_data[1], 32'h22222222);

    // Five downstream wait states with an error response on requester 1
    n1 = 0; n0 = 0; idx1 = -1; err1 = 0; seen[1] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge dck);
      if (c == 0) begin r_psel[1] = 1; r_pwrite[1] = 0; r_paddr[1] = 8'h3C; end
      if (seen[1]) begin r_psel[1] = 0; r_penable[1] = 0; end
      dst_pready = (c >= 7); dst_pslverr = 1;
      #2;
      seen[1] = s1_pready;
      if (s1_pready) begin n1++; if (idx1 < 0) begin idx1 = c; err1 = s1_pslverr; end end
      if (s0_pready) n0++;
    end
    chk("ws_s1_pulses", n1, 1);
    chk("ws_s1_cycle", idx1, 7);
    chk("ws_s1_pslverr", err1, 1);
    chk("ws_s0_pulses", n0, 0);

    // Reset asserted during ACCESS
    @(negedge dck);
    dst_pready = 0; dst_pslverr = 0;
    r_psel[1] = 1; r_paddr[1] = 8'h55;
    repeat (3) @(negedge dck);
    #2;
    chk("rst_mid_pre_grant", grant, 1);
    chk("rst_mid_pre_penable", dst_penable, 1);
    chk_en = 0;
    @(negedge dck);
    #3 drst_n = 1'b0;
    #1;
    chk("rst_mid_dst_psel", dst_psel, 0);
    chk("rst_mid_dst_penable", dst_penable, 0);
    chk("rst_mid_grant", grant, 0);
    chk("rst_mid_s1_pready", s1_pready, 0);
    @(negedge dck);
    clear_inputs();
    drst_n = 1'b1;
    chk_en = 1;
    @(negedge dck);
    r_psel[0] = 1; r_paddr[0] = 8'h22; dst_pready = 1; dst_prdata = 32'h12345678;
    repeat (2) @(negedge dck);
    #2;
    chk("rst_mid_fresh_pready", s0_pready, 1);
    chk("rst_mid_fresh_prdata", s0_prdata, 32'h12345678);
    @(negedge dck);
    r_psel[0] = 0;

`ifdef TWOWIRE_ARB_TIMEOUT_EN
    // Stuck completer: requester 1 is aborted, then pending requester 0 runs
    do_reset();
    r_psel[1] = 1; r_paddr[1] = 8'h70; dst_pready = 0; dst_prdata = 32'hDEADBEEF;
    @(negedge dck);
    r_psel[0] = 1; r_paddr[0] = 8'h71;
    repeat (4) @(negedge dck);
    #2;
    chk("to_s1_pready", s1_pready, 1);
    chk("to_s1_pslverr", s1_pslverr, 1);
    chk("to_s1_prdata", s1_prdata, 0);
    @(negedge dck);
    r_psel[1] = 0;
    #2 chk("to_dst_psel_drop", dst_psel, 0);
    @(negedge dck);
    #2;
    chk("to_s0_granted", grant, 0);
    chk("to_s0_dst_psel", dst_psel, 1);
    chk("to_s0_addr", dst_paddr, 8'h71);
    @(negedge dck);
    dst_pready = 1;
    #2 chk("to_s0_pready", s0_pready, 1);
    @(negedge dck);
    r_psel[0] = 0;
`endif

    // Random traffic
    drain();
    b2b = 0; p_req = 40; p_rdy = 60;
    repeat (1500) step();
    drain();

    // Both requesters back-to-back for 20 transfers
    b2b = 1; p_rdy = 70; track = 1; have_prev = 0;
    n_done[0] = 0; n_done[1] = 0;
    done_seen[0] = 1; done_seen[1] = 1;
    for (int k = 0; k < 400 && (n_done[0] + n_done[1]) < 20; k++) step();
    track = 0;
    chk("b2b_total", n_done[0] + n_done[1], 20);
    chk("b2b_s0_count", n_done[0], 10);
    chk("b2b_s1_count", n_done[1], 10);
    drain();

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
